// File: rtl/wb_trace_pkg.sv
// Shared types and sizing for the writeback trace UART.
// WB_TRACE_PC_EN selects the record/frame layout that carries the instruction PC.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEST_W = 5;
  localparam int VAL_W  = 32;
  localparam int PC_W   = 32;

  localparam int REC_W_BASE       = DEST_W + VAL_W;
  localparam int REC_W_PC         = PC_W + DEST_W + VAL_W;
  localparam int FRAME_BYTES_BASE = 5;
  localparam int FRAME_BYTES_PC   = 9;

`ifdef WB_TRACE_PC_EN
  localparam int REC_W       = REC_W_PC;
  localparam int FRAME_BYTES = FRAME_BYTES_PC;
`else
  localparam int REC_W       = REC_W_BASE;
  localparam int FRAME_BYTES = FRAME_BYTES_BASE;
`endif

  localparam int FRAME_W = FRAME_BYTES * 8;

  // Expands a stored record into transmit order, first byte in the top bits.
  function automatic logic [FRAME_W-1:0] rec_to_frame(input logic [REC_W-1:0] rec);
`ifdef WB_TRACE_PC_EN
    return {rec[REC_W-1 -: PC_W], 3'b000, rec[DEST_W+VAL_W-1:0]};
`else
    return {3'b000, rec};
`endif
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem[rd_ptr_q[AW-1:0]];

  // Full is taken from the registered pointers, so a pop never frees space for a same-cycle push.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Writeback trace serialiser: buffers {dest, writeVal} records and ships each as 8N1 UART bytes.
// Define WB_TRACE_PC_EN to prepend the instruction PC to every record and frame.
module wb_trace_uart_tx
  import wb_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic [4:0]  dest,
  input  logic [31:0] writeVal,
  input  logic [31:0] PC,
  input  logic        clr_ovf,
  output logic        UART_TXD,
  output logic        busy,
  output logic        overflow
);
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE   = 4'(FRAME_BYTES - 1);

  tx_state_e          state_q, state_d;
  logic [15:0]        baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [3:0]         byte_q, byte_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               txd_q, txd_d;
  logic               busy_q, busy_d;
  logic               ovf_q, ovf_d;
  logic [REC_W-1:0]   rec_in, rec_out;
  logic               fifo_full, fifo_empty, pop;
  logic [7:0]         cur_byte;

`ifdef WB_TRACE_PC_EN
  assign rec_in = {PC, dest, writeVal};
`else
  logic unused_pc;
  assign unused_pc = ^PC;
  assign rec_in    = {dest, writeVal};
`endif

  wb_trace_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (WB_EN),
    .din  (rec_in),
    .pop  (pop),
    .dout (rec_out),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign cur_byte = frame_q[FRAME_W-1 -: 8];

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          frame_d = rec_to_frame(rec_out);
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == 16'd0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      DATA: begin
        if (baud_q == 16'd0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      STOP: begin
        if (baud_q == 16'd0) begin
          if (byte_q == LAST_BYTE) begin
            byte_d  = 4'd0;
            state_d = IDLE;
          end else begin
            byte_d  = byte_q + 4'd1;
            frame_d = {frame_q[FRAME_W-9:0], 8'h00};
            baud_d  = BAUD_RELOAD;
            state_d = START;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line, busy and overflow are all registered so the pins are glitch-free.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = cur_byte[bit_q];
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_q != IDLE) || !fifo_empty;
    if (WB_EN && fifo_full) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      frame_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign UART_TXD = txd_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: doc/wb_trace_uart_tx.md
WB_TRACE_UART_TX -- requirements
Module: wb_trace_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, writeback records buffered; power of two, 2..64.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 WB_EN  input  1  writeback strobe from the writeback stage; one record offered per high cycle.
REQ-006 dest  input  5  destination register number of the writeback.
REQ-007 writeVal  input  32  value written to the register file.
REQ-008 PC  input  32  PC of the writing instruction; used only when WB_TRACE_PC_EN is defined.
REQ-009 clr_ovf  input  1  synchronous clear of the overflow flag.
REQ-010 UART_TXD  output  1  8N1 serial out; idle high.
REQ-011 busy  output  1  high while a frame is serialising or the FIFO is non-empty.
REQ-012 overflow  output  1  sticky; set when a record is dropped.

Function
REQ-013 Capture: a WB_EN=1 cycle with FIFO not full at that edge SHALL push {dest, writeVal[, PC]} in one cycle; no other qualification.
REQ-014 Full: WB_EN=1 with FIFO full SHALL drop the record and set overflow next cycle; a same-cycle pop SHALL NOT make room for that push.
REQ-015 overflow SHALL stay set until clr_ovf=1; if a drop and clr_ovf coincide, overflow SHALL end set.
REQ-016 Frame byte order: PC[31:24], PC[23:16], PC[15:8], PC[7:0] (macro only), then {3'b000,dest}, writeVal[31:24], [23:16], [15:8], [7:0]; 5 bytes without the macro, 9 with it.
REQ-017 Byte format: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-018 FSM states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop the record into a shift register on that edge); START->DATA after one bit time; DATA->STOP after 8 bits; STOP->START if more bytes of the frame remain, else STOP->IDLE.
REQ-019 STOP->IDLE->START SHALL add exactly one idle cycle between frames; bytes inside a frame SHALL be back-to-back.
REQ-020 Latency: first start-bit falling edge on UART_TXD SHALL occur 2 cycles after the WB_EN edge that pushed into an empty FIFO with the FSM idle.
REQ-021 Bit counter 0..7 and byte counter 0..8 wrap to 0 on frame end; baud counter counts CLKS_PER_BIT-1 down to 0 and reloads.
REQ-022 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide so that wrap-around distinguishes full from empty.

Reset
REQ-023 rst=0 SHALL immediately force: FSM IDLE, all counters 0, FIFO empty, UART_TXD=1, busy=0, overflow=0.
REQ-024 Reset mid-frame SHALL abandon the frame; after release, UART_TXD SHALL stay high until a new record arrives.

Configuration
REQ-025 Macro WB_TRACE_PC_EN defined: PC port used, records 69 bits, frames 9 bytes; undefined: PC ignored and its storage absent, records 37 bits, frames 5 bytes.

Structure
REQ-026 Package wb_trace_pkg SHALL hold the FSM state encoding, record width constants, and frame byte count constant (both macro variants).
REQ-027 Sub-module wb_trace_fifo (synchronous FIFO, parameterised width and depth, full/empty flags) SHALL be instantiated once.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Single write dest=5'd3, writeVal=32'h12345678, macro off -> bytes 03,12,34,56,78 on UART_TXD, 50 bit-times, busy falls after the final stop bit.
REQ-029 Macro on, PC=32'h00000010, dest=5'd1, writeVal=32'h0000002A -> bytes 00,00,00,10,01,00,00,00,2A.
REQ-030 6 consecutive WB_EN cycles, FSM idle -> 1 record popped at once plus 4 buffered sent, 1 dropped, overflow=1; clr_ovf pulse -> overflow=0.
REQ-031 Reset asserted during the third byte -> UART_TXD=1 in the same cycle; no further transmission; next write produces a complete, correct frame.
REQ-032 Write while FIFO full and FSM popping in the same cycle -> record dropped and overflow set; FIFO count after the edge is FIFO_DEPTH-1.
REQ-033 Bit timing check: every bit period measured at exactly 4 cycles; exactly 1 idle cycle between back-to-back frames.
